// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg: shared AHB bus-matrix transfer/burst encodings and the burst length helper.
package ahb_mtx_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;
  // SEQ beats still owed after the NONSEQ; anything unrecognised behaves as INCR
  function automatic logic [3:0] burst_len(input logic [2:0] hburst);
    return (hburst == HBURST_SINGLE || hburst == HBURST_INCR)   ? 4'd0  :
           (hburst == HBURST_WRAP4  || hburst == HBURST_INCR4)  ? 4'd3  :
           (hburst == HBURST_WRAP8  || hburst == HBURST_INCR8)  ? 4'd7  :
           (hburst == HBURST_WRAP16 || hburst == HBURST_INCR16) ? 4'd15 : 4'd0;
  endfunction
endpackage

// File: rtl/ahb_mtx_arb_beat_cnt.sv
// ahb_mtx_arb_beat_cnt: tracks SEQ beats owed by the current burst and flags when the grant must be held.
// Ports: HCLK/HRESETn clock and async active-low reset; HREADYM, HSELM, HTRANSM, HBURSTM output-port
// address phase; burst_hold high while the current burst still owns the port.
module ahb_mtx_arb_beat_cnt
  import ahb_mtx_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  output logic       burst_hold
);
  logic [3:0] r_beat_cnt;
  logic [3:0] w_len;
  logic [3:0] w_beat_nxt;
  assign w_len = burst_len(HBURSTM);
  // IDLE or deselect ends the burst early; BUSY keeps the owed count
  assign w_beat_nxt = !HSELM                   ? 4'd0 :
                      HTRANSM == HTRANS_NONSEQ ? w_len :
                      HTRANSM == HTRANS_SEQ    ? (r_beat_cnt == 4'd0 ? 4'd0 : r_beat_cnt - 4'd1) :
                      HTRANSM == HTRANS_BUSY   ? r_beat_cnt : 4'd0;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) r_beat_cnt <= '0;
    else if (HREADYM) r_beat_cnt <= w_beat_nxt;
  // the final SEQ (count 1) releases the port so arbitration can switch right after it
  assign burst_hold = HSELM & ((HTRANSM == HTRANS_NONSEQ && w_len != 4'd0) |
                               (HTRANSM == HTRANS_SEQ    && r_beat_cnt > 4'd1) |
                               (HTRANSM == HTRANS_BUSY   && r_beat_cnt != 4'd0));
endmodule

// File: rtl/ahb_mtx_arb_rr.sv
// ahb_mtx_arb_rr: output-stage arbiter choosing which input stage drives the shared slave port.
// Ports: HCLK/HRESETn clock and async active-low reset; req_port per-stage requests; HREADYM, HSELM,
// HTRANSM, HBURSTM, HMASTLOCKM output-port address phase; addr_in_port selected stage; no_port idle flag.
// Optional: define AHB_ARB_STARVE_EN to add per-port wait counters that promote ports waiting
// STARVE_LIMIT cycles ahead of the normal fixed/round-robin order.
module ahb_mtx_arb_rr
  import ahb_mtx_pkg::*;
#(
  parameter int         NUM_PORTS    = 4,
  parameter int         ARB_MODE     = 0,
  parameter logic [7:0] STARVE_LIMIT = 8'd15,
  localparam int        PORT_W       = $clog2(NUM_PORTS)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port
);
  logic [PORT_W-1:0]    r_addr_in_port;
  logic [PORT_W-1:0]    r_rr_ptr;
  logic                 r_no_port;
  logic [PORT_W-1:0]    w_fp_idx;
  logic [PORT_W-1:0]    w_rr_idx;
  logic [PORT_W-1:0]    w_mode_idx;
  logic [PORT_W-1:0]    w_sel;
  logic [PORT_W-1:0]    w_addr_nxt;
  logic                 w_no_port_nxt;
  logic                 w_burst_hold;
  logic                 w_hold;
  logic                 w_grant;
  logic [NUM_PORTS-1:0] w_cand;
  ahb_mtx_arb_beat_cnt u_beat_cnt (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HREADYM    (HREADYM),
    .HSELM      (HSELM),
    .HTRANSM    (HTRANSM),
    .HBURSTM    (HBURSTM),
    .burst_hold (w_burst_hold)
  );
  // the current owner stays a candidate while it has a live transfer on the port
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cand
    assign w_cand[i] = req_port[i] | (r_addr_in_port == PORT_W'(i) && HSELM && HTRANSM != HTRANS_IDLE);
  end
  // descending loops so the lowest index / nearest-after-pointer candidate is the final writer
  always_comb begin
    w_fp_idx = '0;
    w_rr_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      w_fp_idx = w_cand[i] ? PORT_W'(i) : w_fp_idx;
    for (int k = NUM_PORTS; k >= 1; k--)
      w_rr_idx = w_cand[(int'(r_rr_ptr) + k) % NUM_PORTS] ? PORT_W'((int'(r_rr_ptr) + k) % NUM_PORTS) : w_rr_idx;
  end
  assign w_mode_idx = (ARB_MODE == 1) ? w_rr_idx : w_fp_idx;
`ifdef AHB_ARB_STARVE_EN
  logic [7:0]           r_wait [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_starved;
  logic [PORT_W-1:0]    w_st_idx;
  // a port stops accruing wait on the edge it becomes (or stays) the owner
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) for (int i = 0; i < NUM_PORTS; i++) r_wait[i] <= '0;
    else if (HREADYM)
      for (int i = 0; i < NUM_PORTS; i++)
        r_wait[i] <= (!req_port[i] || (!w_no_port_nxt && w_addr_nxt == PORT_W'(i))) ? 8'd0 :
                     r_wait[i] + 8'(r_wait[i] != 8'hff);
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_starve
    assign w_starved[i] = req_port[i] & (r_wait[i] >= STARVE_LIMIT);
  end
  always_comb begin
    w_st_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      w_st_idx = w_starved[i] ? PORT_W'(i) : w_st_idx;
  end
  assign w_sel = |w_starved ? w_st_idx : w_mode_idx;
`else
  assign w_sel = w_mode_idx;
`endif
  assign w_hold        = HMASTLOCKM | w_burst_hold;
  assign w_grant       = !w_hold & |w_cand;
  assign w_addr_nxt    = w_grant ? w_sel : r_addr_in_port;
  assign w_no_port_nxt = w_grant ? 1'b0 : (w_hold | HSELM) ? r_no_port : 1'b1;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_addr_in_port <= '0;
      r_no_port      <= 1'b1;
      r_rr_ptr       <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYM) begin
      r_addr_in_port <= w_addr_nxt;
      r_no_port      <= w_no_port_nxt;
      r_rr_ptr       <= w_grant ? w_sel : r_rr_ptr;
    end
  assign addr_in_port = r_addr_in_port;
  assign no_port      = r_no_port;
endmodule

// File: tb/tb_ahb_mtx_arb_rr.sv
// tb_ahb_mtx_arb_rr: directed checks of fixed-priority, round-robin and 3-port round-robin arbiters.
module tb_ahb_mtx_arb_rr;
  import ahb_mtx_pkg::*;
  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       HREADYM = 1'b1;
  logic       HSELM = 1'b0;
  logic       HMASTLOCKM = 1'b0;
  logic [3:0] req_port = '0;
  logic [1:0] HTRANSM = HTRANS_IDLE;
  logic [2:0] HBURSTM = HBURST_SINGLE;
  logic [1:0] fp_addr, rr_addr, r3_addr;
  logic       fp_np, rr_np, r3_np;
  int         n_chk = 0;
  int         n_fail = 0;
  int         exp_rr [5] = '{0, 1, 2, 3, 0};
  int         exp_r3 [5] = '{0, 1, 2, 0, 1};
  int         exp_st [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  always #5 HCLK = ~HCLK;
  ahb_mtx_arb_rr #(.NUM_PORTS(4), .ARB_MODE(0), .STARVE_LIMIT(8'd3)) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
    .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM), .addr_in_port(fp_addr), .no_port(fp_np));
  ahb_mtx_arb_rr #(.NUM_PORTS(4), .ARB_MODE(1)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
    .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM), .addr_in_port(rr_addr), .no_port(rr_np));
  ahb_mtx_arb_rr #(.NUM_PORTS(3), .ARB_MODE(1)) u_r3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port[2:0]), .HREADYM(HREADYM), .HSELM(HSELM),
    .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM), .addr_in_port(r3_addr), .no_port(r3_np));
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask
  task automatic drive(input logic [3:0] r, input logic s, input logic [1:0] t, input logic [2:0] b, input logic l);
    req_port   = r;
    HSELM      = s;
    HTRANSM    = t;
    HBURSTM    = b;
    HMASTLOCKM = l;
  endtask
  task automatic do_reset;
    HRESETn = 1'b0;
    HREADYM = 1'b1;
    drive(4'b0000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    tick;
    HRESETn = 1'b1;
  endtask
  initial begin
    do_reset;
    chk("rst_fp_addr", fp_addr, 0);
    chk("rst_fp_np", fp_np, 1);
    chk("rst_rr_np", rr_np, 1);
    chk("rst_r3_np", r3_np, 1);
    // basic fixed priority, hold on selected idle, release on deselect, stall
    drive(4'b0110, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    chk("t1_addr", fp_addr, 1);
    chk("t1_np", fp_np, 0);
    drive(4'b0000, 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    chk("t1_sel_hold_addr", fp_addr, 1);
    chk("t1_sel_hold_np", fp_np, 0);
    drive(4'b0000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    chk("t1_nop_addr", fp_addr, 1);
    chk("t1_nop_np", fp_np, 1);
    HREADYM = 1'b0;
    drive(4'b0001, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    chk("t1_stall_addr", fp_addr, 1);
    chk("t1_stall_np", fp_np, 1);
    HREADYM = 1'b1;
    tick;
    chk("t1_go_addr", fp_addr, 0);
    chk("t1_go_np", fp_np, 0);
    // round robin rotation and 3-port wrap
    do_reset;
    drive(4'b1111, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    for (int n = 0; n < 5; n++) begin
      tick;
      chk($sformatf("t2_rr%0d", n), rr_addr, exp_rr[n]);
      chk($sformatf("t2_r3_%0d", n), r3_addr, exp_r3[n]);
      if (n < 3) chk($sformatf("t2_fp%0d", n), fp_addr, 0);
    end
    drive(4'b1001, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    chk("t2_rr_sparse_a", rr_addr, 3);
    tick;
    chk("t2_rr_sparse_b", rr_addr, 0);
    // INCR4 hold with a stall in the middle
    do_reset;
    drive(4'b0100, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    chk("t3_own", fp_addr, 2);
    drive(4'b0001, 1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b0);
    tick;
    chk("t3_ns", fp_addr, 2);
    chk("t3_ns_cnt", u_fp.u_beat_cnt.r_beat_cnt, 3);
    drive(4'b0001, 1'b1, HTRANS_SEQ, HBURST_INCR4, 1'b0);
    tick;
    chk("t3_s1", fp_addr, 2);
    HREADYM = 1'b0;
    tick;
    chk("t3_stall", fp_addr, 2);
    chk("t3_stall_cnt", u_fp.u_beat_cnt.r_beat_cnt, 2);
    HREADYM = 1'b1;
    tick;
    chk("t3_s2", fp_addr, 2);
    tick;
    chk("t3_s3", fp_addr, 0);
    chk("t3_end_cnt", u_fp.u_beat_cnt.r_beat_cnt, 0);
    // INCR8 cut short by IDLE
    do_reset;
    drive(4'b1000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    chk("t4_own", fp_addr, 3);
    drive(4'b0010, 1'b1, HTRANS_NONSEQ, HBURST_INCR8, 1'b0);
    tick;
    chk("t4_ns", fp_addr, 3);
    chk("t4_ns_cnt", u_fp.u_beat_cnt.r_beat_cnt, 7);
    drive(4'b0010, 1'b1, HTRANS_SEQ, HBURST_INCR8, 1'b0);
    tick;
    chk("t4_s1", fp_addr, 3);
    tick;
    chk("t4_s2", fp_addr, 3);
    drive(4'b0010, 1'b1, HTRANS_IDLE, HBURST_INCR8, 1'b0);
    tick;
    chk("t4_idle_addr", fp_addr, 1);
    chk("t4_idle_cnt", u_fp.u_beat_cnt.r_beat_cnt, 0);
    // locked sequence, then reset mid lock/burst
    do_reset;
    drive(4'b1000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    chk("t5_own", fp_addr, 3);
    drive(4'b0001, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    for (int n = 0; n < 3; n++) begin
      tick;
      chk($sformatf("t5_lock%0d", n), fp_addr, 3);
    end
    drive(4'b0001, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick;
    chk("t5_unlock", fp_addr, 0);
    drive(4'b1000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick;
    chk("t5_own2", fp_addr, 3);
    drive(4'b0010, 1'b1, HTRANS_NONSEQ, HBURST_INCR8, 1'b1);
    tick;
    chk("t5_lockburst", fp_addr, 3);
    HRESETn = 1'b0;
    #2;
    chk("t5_async_addr", fp_addr, 0);
    chk("t5_async_np", fp_np, 1);
    chk("t5_async_cnt", u_fp.u_beat_cnt.r_beat_cnt, 0);
    #1;
    HRESETn = 1'b1;
    drive(4'b0010, 1'b1, HTRANS_SEQ, HBURST_INCR8, 1'b0);
    tick;
    chk("t5_nohold_np", fp_np, 0);
    chk("t5_nohold_addr", fp_addr, 0);
`ifdef AHB_ARB_STARVE_EN
    do_reset;
    drive(4'b0011, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    for (int n = 0; n < 8; n++) begin
      tick;
      chk($sformatf("t6_st%0d", n), fp_addr, exp_st[n]);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
